// File: rtl/dlx_pipe_pkg.sv
// dlx_pipe_pkg -- shared constants and types for the DLX pipeline control blocks.
//   REG_W      : default register-specifier width
//   MC_CNT_W   : width of the multi-cycle stall down-counter
//   PERF_CNT_W : width of the saturating performance counters
//   hz_state_e : hazard controller FSM states (RUN, MC_WAIT)
package dlx_pipe_pkg;

    localparam int REG_W      = 5;
    localparam int MC_CNT_W   = 8;
    localparam int PERF_CNT_W = 16;

    typedef enum logic [0:0] {
        RUN     = 1'b0,
        MC_WAIT = 1'b1
    } hz_state_e;

endpackage

// File: rtl/sat_counter.sv
// sat_counter -- W-bit up-counter that sticks at all-ones instead of wrapping.
//   clk   : clock, rising edge
//   rst   : synchronous active-high clear
//   inc   : count this cycle
//   count : current value
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl -- pipeline hazard controller for the 5-stage DLX core.
// Handles taken-branch flush, load-use stall and multi-cycle (mul/div) stall.
// Outputs are combinational from the registered FSM state, mc_cnt and the
// current inputs.
//
// Ports:
//   clk, rst          : clock (rising edge), synchronous active-high reset
//   id_rs1, id_rs2    : ID-stage source registers
//   id_uses_rs2       : ID instruction reads rs2
//   id_mc_start       : ID instruction is a multi-cycle op
//   idex_memread      : EX-stage instruction is a load
//   idex_rd           : EX-stage destination register
//   branch_taken      : taken branch/jump resolved this cycle
//   pc_write          : PC updates this cycle
//   IFID_write        : IF/ID register loads a new instruction
//   IFflush           : IF/ID instruction field cleared
//   idex_bubble       : ID/EX control fields zeroed
//   mc_busy           : multi-cycle op is holding the pipeline in MC_WAIT
//   stall_cnt         : (HAZARD_CTRL_PERF_EN) saturating count of pc_write=0 cycles
//   flush_cnt         : (HAZARD_CTRL_PERF_EN) saturating count of IFflush cycles
//
// Build option: define HAZARD_CTRL_PERF_EN to add the performance counters.
module hazard_ctrl #(
    parameter int REG_W  = dlx_pipe_pkg::REG_W,
    parameter int MC_LAT = 4                     // legal 1..255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_uses_rs2,
    input  logic             id_mc_start,
    input  logic             idex_memread,
    input  logic [REG_W-1:0] idex_rd,
    input  logic             branch_taken,
    output logic             pc_write,
    output logic             IFID_write,
    output logic             IFflush,
    output logic             idex_bubble,
    output logic             mc_busy
`ifdef HAZARD_CTRL_PERF_EN
    ,
    output logic [dlx_pipe_pkg::PERF_CNT_W-1:0] stall_cnt,
    output logic [dlx_pipe_pkg::PERF_CNT_W-1:0] flush_cnt
`endif
);

    import dlx_pipe_pkg::*;

    hz_state_e             state, state_nxt;
    logic [MC_CNT_W-1:0]   mc_cnt, mc_cnt_nxt;
    logic                  load_use;

    // Register 0 is hardwired to zero, so a load targeting it never creates a hazard.
    assign load_use = idex_memread && (idex_rd != '0) &&
                      ((idex_rd == id_rs1) || (id_uses_rs2 && (idex_rd == id_rs2)));

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= RUN;
            mc_cnt <= '0;
        end else begin
            state  <= state_nxt;
            mc_cnt <= mc_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        mc_cnt_nxt  = mc_cnt;
        pc_write    = 1'b1;
        IFID_write  = 1'b1;
        IFflush     = 1'b0;
        idex_bubble = 1'b0;
        mc_busy     = 1'b0;

        if (rst) begin
            pc_write    = 1'b0;
            IFID_write  = 1'b0;
            idex_bubble = 1'b1;
        end else begin
            unique case (state)
                RUN: begin
                    if (branch_taken) begin
                        // Wrong-path instructions are squashed; the PC still moves to the target.
                        IFflush     = 1'b1;
                        idex_bubble = 1'b1;
                    end else if (id_mc_start) begin
                        // Start cycle is the first of MC_LAT stall cycles.
                        pc_write    = 1'b0;
                        IFID_write  = 1'b0;
                        idex_bubble = 1'b1;
                        mc_cnt_nxt  = MC_CNT_W'(MC_LAT - 1);
                        state_nxt   = MC_WAIT;
                    end else if (load_use) begin
                        pc_write    = 1'b0;
                        IFID_write  = 1'b0;
                        idex_bubble = 1'b1;
                    end
                end
                MC_WAIT: begin
                    if (mc_cnt != '0) begin
                        pc_write    = 1'b0;
                        IFID_write  = 1'b0;
                        idex_bubble = 1'b1;
                        mc_busy     = 1'b1;
                        mc_cnt_nxt  = mc_cnt - MC_CNT_W'(1);
                    end else begin
                        // Release cycle: pipeline advances normally, op result is available.
                        state_nxt = RUN;
                    end
                end
                default: state_nxt = RUN;
            endcase
        end
    end

`ifdef HAZARD_CTRL_PERF_EN
    sat_counter #(.W(PERF_CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (!rst && !pc_write),
        .count (stall_cnt)
    );

    sat_counter #(.W(PERF_CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (IFflush),
        .count (flush_cnt)
    );
`endif

`ifndef SYNTHESIS
    // A branch cannot legally resolve while the pipeline is frozen behind a mul/div.
    a_no_branch_in_mc_wait: assert property (@(posedge clk) disable iff (rst)
        !((state == MC_WAIT) && branch_taken))
        else $error("branch_taken asserted while in MC_WAIT");
`endif

endmodule
